// File: rtl/riscp_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscp_pipe_pkg
// Shared types for the IITB-RISC-23 elastic inter-stage registers.
//   pipe_state_t      : occupancy state of an elastic stage (EMPTY/ONE/FULL)
//   PIPE_OCC_W        : width of the occupancy count output
//   *_payload_t       : per-stage payload layouts; a stage packs its struct
//                       into the DATA_W vector handed to pipe_stage_elastic
//   occ_of_state      : maps a state to its entry count
// ---------------------------------------------------------------------------
package riscp_pipe_pkg;

    localparam int unsigned PIPE_OCC_W = 2;

    // Encoding doubles as the entry count: EMPTY=0, ONE=1, FULL=2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // MEM/WB stage payload.
    typedef struct packed {
        logic        rf_we;
        logic [2:0]  rf_waddr;
        logic [1:0]  wb_sel;
        logic [15:0] alu_res;
        logic [15:0] mem_rdata;
        logic [15:0] pc2;
        logic [15:0] imm_eff;
    } mem_wb_payload_t;

    localparam int unsigned MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

    // EX/MEM stage payload.
    typedef struct packed {
        logic        rf_we;
        logic [2:0]  rf_waddr;
        logic [1:0]  wb_sel;
        logic        mem_we;
        logic        mem_re;
        logic [15:0] alu_res;
        logic [15:0] store_data;
        logic [15:0] pc2;
        logic [15:0] imm_eff;
    } ex_mem_payload_t;

    localparam int unsigned EX_MEM_PAYLOAD_W = $bits(ex_mem_payload_t);

    function automatic logic [PIPE_OCC_W-1:0] occ_of_state(pipe_state_t s);
        logic [PIPE_OCC_W-1:0] occ;
        unique case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
// Elastic pipeline register moving one packed payload per cycle downstream
// under a valid/ready handshake, with synchronous flush-to-NOP.
//
// Build option: define RISC_PIPE_SKID_EN for the 2-entry skid version
// (registered in_ready, occupancy 0..2). Without it the stage holds a single
// entry and in_ready = !out_valid || out_ready (combinational), which matches
// the old stall/flush register with stall = !out_ready.
//
// Parameters
//   DATA_W         payload width (>= 1)
//   CLEAR_ON_FLUSH 1: zero payload registers on flush; 0: only drop valid
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush      in   synchronous kill of all held entries (highest priority)
//   in_valid   in   upstream beat present
//   in_ready   out  stage can accept a beat
//   in_data    in   upstream payload
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts
//   out_data   out  downstream payload (always the main register)
//   occupancy  out  entries held
// ---------------------------------------------------------------------------
module pipe_stage_elastic
    import riscp_pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = 16,
    parameter bit          CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [PIPE_OCC_W-1:0] occupancy
);

    pipe_state_t       state_q;
    logic [DATA_W-1:0] main_q;
    logic              accept;
    logic              release_beat;

    assign accept       = in_valid && in_ready;
    assign release_beat = out_valid && out_ready;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

`ifdef RISC_PIPE_SKID_EN

    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;

    // in_ready_q always tracks (next state != FULL), so it is updated in every
    // branch that changes whether the next state is FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            // A beat handshaken now is dropped; a release now has already
            // been sampled downstream, so nothing more to do for it.
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && release_beat) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q     <= in_data;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (release_beat) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a release can happen.
                    if (release_beat) begin
                        main_q     <= skid_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign occupancy = occ_of_state(state_q);

`else

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    // Accept in ONE implies out_ready, i.e. a simultaneous release.
                    if (accept) begin
                        main_q <= in_data;
                    end else if (release_beat) begin
                        state_q <= EMPTY;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = !out_valid || out_ready;
    assign occupancy = {1'b0, (state_q == ONE)};

`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Self-checking bench for pipe_stage_elastic. A queue-based model tracks the
// held beats; every cycle the DUT outputs are compared against it. Build with
// or without RISC_PIPE_SKID_EN to match the RTL configuration.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;
    import riscp_pipe_pkg::*;

    localparam int unsigned DW  = 16;
    localparam bit          CLR = 1'b1;
`ifdef RISC_PIPE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         out_data;
    logic [PIPE_OCC_W-1:0] occupancy;

    pipe_stage_elastic #(
        .DATA_W        (DW),
        .CLEAR_ON_FLUSH(CLR)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: FIFO of held beats, last value shown on out_data,
    // and the registered ready flag of the skid build.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_shadow;
    bit            m_ready;

    task automatic model_reset();
        mq.delete();
        m_shadow = '0;
        m_ready  = 1'b1;
    endtask

    function automatic bit exp_in_ready();
`ifdef RISC_PIPE_SKID_EN
        return m_ready;
`else
        return (mq.size() == 0) || out_ready;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_out_data();
        return (mq.size() > 0) ? mq[0] : m_shadow;
    endfunction

    // Drive one cycle of stimulus, compare outputs, then advance the model.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit r, input bit f,
                         input string tag);
        bit acc;
        bit rel;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".out_data"},  32'(out_data),  32'(exp_out_data()));
        check({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
        check({tag, ".in_ready"},  32'(in_ready),  32'(exp_in_ready()));
        acc = v && exp_in_ready();
        rel = (mq.size() > 0) && r;
        @(posedge clk);
        if (f) begin
            mq.delete();
            if (CLR) m_shadow = '0;
        end else begin
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        if (mq.size() > 0) m_shadow = mq[0];
        m_ready = (mq.size() < CAP);
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state.
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.out_data",  32'(out_data),  32'd0);
        check("rst.occupancy", 32'(occupancy), 32'd0);
        check("rst.in_ready",  32'(in_ready),  32'd1);
        #11;
        rst_n = 1'b1;

        // Streaming at full rate.
        cycle(1'b1, 16'h0001, 1'b1, 1'b0, "stream0");
        cycle(1'b1, 16'h0002, 1'b1, 1'b0, "stream1");
        cycle(1'b1, 16'h0003, 1'b1, 1'b0, "stream2");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "stream3");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "stream4");

        // Backpressure then in-order drain.
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, "bp0");
        cycle(1'b1, 16'hBBBB, 1'b0, 1'b0, "bp1");
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, "bp2");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "bp3");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "bp4");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "bp5");

        // Flush while holding entries; 0xCCCC offered in the flush cycle.
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b0, "fl0");
        cycle(1'b1, 16'hBBBB, 1'b0, 1'b0, "fl1");
        cycle(1'b1, 16'hCCCC, 1'b0, 1'b1, "fl2");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "fl3");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "fl4");

        // Hold stability with toggling input data.
        cycle(1'b1, 16'h1357, 1'b0, 1'b0, "hold0");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, (i % 2 == 0) ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, "hold");
        end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "hold6");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "hold7");
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, "hold8");

        // in_ready timing relative to out_ready within one cycle.
`ifdef RISC_PIPE_SKID_EN
        cycle(1'b1, 16'h2468, 1'b0, 1'b0, "rdy0");
        cycle(1'b1, 16'h1234, 1'b0, 1'b0, "rdy1");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("skid_rdy_lo", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("skid_rdy_hold", 32'(in_ready), 32'd0);
        out_ready = 1'b0;
        #1;
`else
        cycle(1'b1, 16'h2468, 1'b0, 1'b0, "rdy0");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("ns_rdy_lo", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        check("ns_rdy_hi", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        #1;
        check("ns_rdy_lo2", 32'(in_ready), 32'd0);
`endif

        // Asynchronous reset mid-cycle while holding entries.
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, "ar0");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.occupancy", 32'(occupancy), 32'd0);
        check("arst.out_data",  32'(out_data),  32'd0);
        check("arst.in_ready",  32'(in_ready),  32'd1);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline register for the IITB-RISC-23 core. It is the generic replacement for the fixed stall/flush inter-stage registers, e.g. MEM/WB. A stage packs its control and data fields into one payload vector. The block moves that payload downstream under a valid/ready handshake at one beat per cycle, supports flush-to-NOP, and can optionally decouple ready timing with a 2-entry skid buffer.

## Interface
- DATA_W, 16: payload width in bits, 1 or more.
- CLEAR_ON_FLUSH, 1: when 1, payload registers are zeroed on flush; when 0, only the valid state is cleared.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  downstream payload.
- occupancy  out  2  number of entries held (0..2).

## Operation
- Accept happens when in_valid && in_ready. Release happens when out_valid && out_ready. Payload is only sampled on accept.
- Reset values: out_valid=0, out_data=0, occupancy=0, in_ready=1. Internal state is EMPTY and the skid register is 0.
- Skid mode (macro defined) uses a 3-state FSM: EMPTY, ONE, FULL.
  - EMPTY: on accept, main<=in_data and go to ONE.
  - ONE, accept and release together: main<=in_data, stay in ONE.
  - ONE, accept only: skid<=in_data, go to FULL.
  - ONE, release only: go to EMPTY.
  - ONE, neither: hold.
  - FULL: in_ready=0. On release, main<=skid and go to ONE. Otherwise hold.
- out_valid = (state != EMPTY). out_data = main. occupancy is 0, 1 or 2 for EMPTY, ONE and FULL.
- in_ready comes from a register and is the decode of the next state (!= FULL). There is no combinational path from out_ready to in_ready.
- Order is strictly preserved: the skid entry always leaves after main.
- Flush has highest priority.
  - Next state is EMPTY and in_ready=1. If CLEAR_ON_FLUSH=1, main and skid are zeroed.
  - A beat handshaken in the flush cycle counts as accepted and is discarded.
  - A release in the flush cycle still completes, because downstream already sampled it.
- Holding is guaranteed: while out_valid && !out_ready, out_data stays stable.
- Reset mid-operation drops all entries immediately (asynchronous). Any in-flight beat is lost by design.

## Timing
- Latency: a beat accepted at edge N is on out_valid/out_data after edge N (visible in cycle N+1).
- Throughput: 1 beat per cycle sustained while out_ready=1.
- Skid mode: in_ready deasserts the cycle after FULL is entered and reasserts the cycle after the first release from FULL.
- Non-skid mode: in_ready = !out_valid || out_ready, combinational.
- Flush: out_valid=0 from the next cycle. flush during reset has no effect.

## Configuration
- The macro is RISC_PIPE_SKID_EN.
- When defined: 2-entry skid FSM as above, registered in_ready, occupancy is 0..2.
- When undefined: single entry (EMPTY/ONE only), combinational in_ready, occupancy[1] tied 0, no skid register.
  - This mode is functionally equivalent to the old stall/flush register, with stall = !out_ready.

## Structure
- The shared package riscp_pipe_pkg holds:
  - typedef enum logic [1:0] pipe_state_t {EMPTY, ONE, FULL};
  - the localparam PIPE_OCC_W=2;
  - payload struct typedefs per stage (e.g. mem_wb_payload_t: rf_we, rf_waddr[2:0], wb_sel[1:0], alu_res, mem_rdata, pc2, imm_eff), packed to DATA_W by the caller.
- Single module, no sub-module. The FSM and datapath are small enough to stay flat.

## Test plan
- Streaming: in_valid=1 continuously with in_data=0x0001,0x0002,0x0003, out_ready=1 → out_data shows 0x0001..0x0003 on consecutive cycles, one cycle late; occupancy stays 1.
- Backpressure (skid): accept 0xAAAA, then 0xBBBB with out_ready=0 → occupancy=2 and in_ready=0 next cycle. Raise out_ready → 0xAAAA then 0xBBBB are released in order, and in_ready returns to 1.
- Flush when FULL with CLEAR_ON_FLUSH=1 → next cycle out_valid=0, occupancy=0, out_data=0x0000, in_ready=1. A beat 0xCCCC presented in the flush cycle never appears.
- Hold stability: out_valid=1 with out_ready=0 for 5 cycles and in_data toggling → out_data constant. No second entry is taken beyond occupancy=2.
- Async reset: assert rst_n=0 mid-cycle while FULL → out_valid, occupancy and out_data go to 0 immediately, without waiting for a clock edge; in_ready=1.
- Non-skid build: with out_valid=1, toggle out_ready → in_ready follows out_ready in the same cycle.
